// File: rtl/vga_text_scanner.sv
// vga_text_scanner
//   Pixel-clock-domain scanner for an 80x30 text screen of 8x16 character cells.
//   It produces 640x480@60 VGA timing and reads the character video RAM and an
//   external font ROM through a 3-stage pipeline. RGB, hsync, vsync and
//   frame_start_o all leave the block registered, 3 cycles after the counter
//   value they describe, with no skew between sync and pixel data.
//
// Ports:
//   clk_pxl_i      pixel clock (only clock)
//   pxl_reset_i    synchronous active-high reset
//   vram_addr_o    character address into video RAM (0 outside the visible area)
//   vram_data_i    character code, valid 1 cycle after vram_addr_o
//   font_addr_o    {char[7:0], glyph_row[3:0]} into the font ROM
//   font_data_i    glyph row, bit7 = leftmost pixel, valid 1 cycle after font_addr_o
//   vga_red_o/vga_green_o/vga_blue_o   RGB444 pixel
//   vga_hsync_o/vga_vsync_o            active-low syncs
//   frame_start_o  1-cycle pulse aligned with pixel (0,0) on the outputs
//
// Optional build macro VGA_TEXT_CURSOR_EN:
//   adds cursor_col_i[6:0], cursor_row_i[4:0], cursor_en_i[0:0] and a 6-bit
//   frame counter; the cursor cell shows a solid underline on glyph rows 14-15
//   while frame_ctr[5] is set (64-frame blink period).
module vga_text_scanner #(
  parameter int          H_VISIBLE = 640,
  parameter int          H_FRONT   = 16,
  parameter int          H_SYNC    = 96,
  parameter int          H_BACK    = 48,
  parameter int          V_VISIBLE = 480,
  parameter int          V_FRONT   = 10,
  parameter int          V_SYNC    = 2,
  parameter int          V_BACK    = 33,
  parameter int          COLS      = 80,
  parameter logic [11:0] FG_COLOR  = 12'hFFF,
  parameter logic [11:0] BG_COLOR  = 12'h000
) (
  input  logic        clk_pxl_i,
  input  logic        pxl_reset_i,
  output logic [11:0] vram_addr_o,
  input  logic [7:0]  vram_data_i,
  output logic [11:0] font_addr_o,
  input  logic [7:0]  font_data_i,
  output logic [3:0]  vga_red_o,
  output logic [3:0]  vga_green_o,
  output logic [3:0]  vga_blue_o,
  output logic        vga_hsync_o,
  output logic        vga_vsync_o,
  output logic        frame_start_o
`ifdef VGA_TEXT_CURSOR_EN
  ,
  input  logic [6:0]  cursor_col_i,
  input  logic [4:0]  cursor_row_i,
  input  logic [0:0]  cursor_en_i
`endif
);

  localparam logic [9:0]  H_LAST   = 10'(H_VISIBLE + H_FRONT + H_SYNC + H_BACK - 1);
  localparam logic [9:0]  V_LAST   = 10'(V_VISIBLE + V_FRONT + V_SYNC + V_BACK - 1);
  localparam logic [9:0]  H_VIS    = 10'(H_VISIBLE);
  localparam logic [9:0]  V_VIS    = 10'(V_VISIBLE);
  localparam logic [9:0]  HS_BEG   = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0]  HS_END   = 10'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [9:0]  VS_BEG   = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0]  VS_END   = 10'(V_VISIBLE + V_FRONT + V_SYNC);
  localparam logic [11:0] ROW_STEP = 12'(COLS);

  // Stage 0: counters and running row base address
  logic [9:0]  r_h;
  logic [9:0]  r_v;
  logic [11:0] r_row_base;
  logic        w_h_last;
  logic        w_v_last;
  logic        w_visible;
  logic        w_hsync_act;
  logic        w_vsync_act;
  logic        w_frame;
  logic        w_cursor;
  logic        w_pix_bit;

  // Pipeline delay registers (sync flags are stored active-high)
  logic [3:0]  r_vrow_d1;
  logic [2:0]  r_hpix_d1;
  logic [2:0]  r_hpix_d2;
  logic        r_blank_d1;
  logic        r_blank_d2;
  logic        r_hs_d1;
  logic        r_hs_d2;
  logic        r_vs_d1;
  logic        r_vs_d2;
  logic        r_fs_d1;
  logic        r_fs_d2;
  logic        r_cur_d1;
  logic        r_cur_d2;

  // Stage 3 output registers
  logic [11:0] r_rgb;
  logic        r_hsync;
  logic        r_vsync;
  logic        r_frame_start;

  assign w_h_last    = (r_h == H_LAST);
  assign w_v_last    = (r_v == V_LAST);
  assign w_visible   = (r_h < H_VIS) && (r_v < V_VIS);
  assign w_hsync_act = (r_h >= HS_BEG) && (r_h < HS_END);
  assign w_vsync_act = (r_v >= VS_BEG) && (r_v < VS_END);
  assign w_frame     = (r_h == 10'd0) && (r_v == 10'd0);

`ifdef VGA_TEXT_CURSOR_EN
  logic [5:0] r_frame_ctr;

  // Frame counter for the cursor blink, advances on every v wrap
  always_ff @(posedge clk_pxl_i) begin
    if (pxl_reset_i) begin
      r_frame_ctr <= 6'd0;
    end else if (w_h_last && w_v_last) begin
      r_frame_ctr <= r_frame_ctr + 6'd1;
    end else begin
      r_frame_ctr <= r_frame_ctr;
    end
  end

  // Cursor cell, glyph rows 14 and 15 only (v[3:1] == 3'b111)
  assign w_cursor = cursor_en_i[0] && r_frame_ctr[5] &&
                    (r_h[9:3] == cursor_col_i) && (r_v[8:4] == cursor_row_i) &&
                    (r_v[3:1] == 3'b111);
`else
  assign w_cursor = 1'b0;
`endif

  // Raster counters; row_base steps by one text row after every 16th line,
  // so the character address needs only an adder
  always_ff @(posedge clk_pxl_i) begin
    if (pxl_reset_i) begin
      r_h        <= 10'd0;
      r_v        <= 10'd0;
      r_row_base <= 12'd0;
    end else if (w_h_last) begin
      r_h <= 10'd0;
      if (w_v_last) begin
        r_v        <= 10'd0;
        r_row_base <= 12'd0;
      end else if (r_v[3:0] == 4'hF) begin
        r_v        <= r_v + 10'd1;
        r_row_base <= r_row_base + ROW_STEP;
      end else begin
        r_v        <= r_v + 10'd1;
        r_row_base <= r_row_base;
      end
    end else begin
      r_h        <= r_h + 10'd1;
      r_v        <= r_v;
      r_row_base <= r_row_base;
    end
  end

  // Character address, forced to 0 outside the visible area
  always_comb begin
    vram_addr_o = 12'd0;
    if (w_visible) begin
      vram_addr_o = r_row_base + {5'd0, r_h[9:3]};
    end else begin
      vram_addr_o = 12'd0;
    end
  end

  // Stage 1: glyph row address straight from the RAM data
  assign font_addr_o = {vram_data_i, r_vrow_d1};

  // Stage 2: select the pixel bit, MSB is the leftmost pixel
  always_comb begin
    w_pix_bit = font_data_i[3'd7 - r_hpix_d2] | r_cur_d2;
  end

  // Delay line carrying per-pixel side information to the output stage
  always_ff @(posedge clk_pxl_i) begin
    if (pxl_reset_i) begin
      r_vrow_d1  <= 4'd0;
      r_hpix_d1  <= 3'd0;
      r_hpix_d2  <= 3'd0;
      r_blank_d1 <= 1'b1;
      r_blank_d2 <= 1'b1;
      r_hs_d1    <= 1'b0;
      r_hs_d2    <= 1'b0;
      r_vs_d1    <= 1'b0;
      r_vs_d2    <= 1'b0;
      r_fs_d1    <= 1'b0;
      r_fs_d2    <= 1'b0;
      r_cur_d1   <= 1'b0;
      r_cur_d2   <= 1'b0;
    end else begin
      r_vrow_d1  <= r_v[3:0];
      r_hpix_d1  <= r_h[2:0];
      r_hpix_d2  <= r_hpix_d1;
      r_blank_d1 <= ~w_visible;
      r_blank_d2 <= r_blank_d1;
      r_hs_d1    <= w_hsync_act;
      r_hs_d2    <= r_hs_d1;
      r_vs_d1    <= w_vsync_act;
      r_vs_d2    <= r_vs_d1;
      r_fs_d1    <= w_frame;
      r_fs_d2    <= r_fs_d1;
      r_cur_d1   <= w_cursor;
      r_cur_d2   <= r_cur_d1;
    end
  end

  // Stage 3: registered colour and sync outputs
  always_ff @(posedge clk_pxl_i) begin
    if (pxl_reset_i) begin
      r_rgb         <= 12'h000;
      r_hsync       <= 1'b1;
      r_vsync       <= 1'b1;
      r_frame_start <= 1'b0;
    end else begin
      if (r_blank_d2) begin
        r_rgb <= 12'h000;
      end else if (w_pix_bit) begin
        r_rgb <= FG_COLOR;
      end else begin
        r_rgb <= BG_COLOR;
      end
      r_hsync       <= ~r_hs_d2;
      r_vsync       <= ~r_vs_d2;
      r_frame_start <= r_fs_d2;
    end
  end

  assign vga_red_o     = r_rgb[11:8];
  assign vga_green_o   = r_rgb[7:4];
  assign vga_blue_o    = r_rgb[3:0];
  assign vga_hsync_o   = r_hsync;
  assign vga_vsync_o   = r_vsync;
  assign frame_start_o = r_frame_start;

endmodule

// File: tb/tb_vga_text_scanner.sv
// Bench for vga_text_scanner. The vertical timing is shortened (32 visible
// lines, 36 total) so whole frames fit in a short run; horizontal timing is
// the standard 800-cycle line. Cycle n = 0 is the first cycle after reset with
// the scanner at (0,0); the reference model derives every output from n.
module tb_vga_text_scanner;

  localparam int HV = 640, HF = 16, HS = 96, HB = 48;
  localparam int VV = 32, VF = 1, VS = 2, VB = 1;
  localparam int HT = HV + HF + HS + HB;
  localparam int VT = VV + VF + VS + VB;
  localparam int FRAME = HT * VT;
  localparam int RST_AT = 20 * HT + 300;

  logic        clk = 1'b0;
  logic        rst;
  logic [11:0] vram_addr;
  logic [7:0]  vram_data;
  logic [11:0] font_addr;
  logic [7:0]  font_data;
  logic [3:0]  red, green, blue;
  logic        hsync, vsync, fstart;

  logic [7:0]  vram_mem [4096];
  logic [7:0]  font_mem [4096];
  logic [11:0] addr_log [FRAME];
  logic [11:0] rgb_log  [HT];

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    int          kind;  // 0: vram_addr at (h,v), 1: rgb of pixel (h,v=0)
    int          h;
    int          v;
    logic [11:0] exp;
  } vec_t;
  vec_t vecs [16];

  always #5 clk = ~clk;

  vga_text_scanner #(
    .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
    .COLS(80), .FG_COLOR(12'hFFF), .BG_COLOR(12'h000)
  ) dut (
    .clk_pxl_i    (clk),
    .pxl_reset_i  (rst),
    .vram_addr_o  (vram_addr),
    .vram_data_i  (vram_data),
    .font_addr_o  (font_addr),
    .font_data_i  (font_data),
    .vga_red_o    (red),
    .vga_green_o  (green),
    .vga_blue_o   (blue),
    .vga_hsync_o  (hsync),
    .vga_vsync_o  (vsync),
    .frame_start_o(fstart)
  );

  // Registered video RAM and font ROM models
  always @(posedge clk) begin
    vram_data <= vram_mem[vram_addr];
    font_data <= font_mem[font_addr];
  end

  function automatic logic [11:0] exp_addr(int n);
    int h, v;
    h = n % HT;
    v = (n / HT) % VT;
    if (h < HV && v < VV) return 12'((v / 16) * 80 + h / 8);
    else return 12'd0;
  endfunction

  // {rgb[11:0], hsync, vsync, frame_start} expected at cycle n
  function automatic logic [14:0] exp_out(int n);
    int p, x, y;
    logic [7:0]  ch, gl;
    logic [11:0] rgb;
    if (n < 3) return {12'h000, 1'b1, 1'b1, 1'b0};
    p = n - 3;
    x = p % HT;
    y = (p / HT) % VT;
    rgb = 12'h000;
    if (x < HV && y < VV) begin
      ch  = vram_mem[(y / 16) * 80 + x / 8];
      gl  = font_mem[{ch, 4'(y % 16)}];
      rgb = gl[7 - (x % 8)] ? 12'hFFF : 12'h000;
    end
    return {rgb, !(x >= HV + HF && x < HV + HF + HS),
            !(y >= VV + VF && y < VV + VF + VS), (x == 0 && y == 0)};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cycle_check(input int n);
    check($sformatf("vram_addr n=%0d", n), 32'(vram_addr), 32'(exp_addr(n)));
    if (n >= 1)
      check($sformatf("font_addr n=%0d", n), 32'(font_addr),
            32'({vram_mem[exp_addr(n - 1)], 4'((((n - 1) / HT) % VT) % 16)}));
    check($sformatf("rgb/hs/vs/fs n=%0d", n),
          32'({red, green, blue, hsync, vsync, fstart}), 32'(exp_out(n)));
  endtask

  initial begin
    int fs_first, fs_second, fs_count, hs_low, vs_low, vs_first, vs_last;

    vecs[0]  = '{0,   8,  0, 12'd1};
    vecs[1]  = '{0,   0, 16, 12'd80};
    vecs[2]  = '{0, 639, 31, 12'd159};
    vecs[3]  = '{0, 700, 10, 12'd0};
    vecs[4]  = '{0, 639,  0, 12'd79};
    vecs[5]  = '{0,   0, 32, 12'd0};
    vecs[6]  = '{0,  15, 17, 12'd81};
    vecs[7]  = '{0, 640,  5, 12'd0};
    vecs[8]  = '{0,   0, 35, 12'd0};
    vecs[9]  = '{0, 799,  0, 12'd0};
    vecs[10] = '{1,   0,  0, 12'hFFF};
    vecs[11] = '{1,   1,  0, 12'h000};
    vecs[12] = '{1,   3,  0, 12'h000};
    vecs[13] = '{1,   6,  0, 12'h000};
    vecs[14] = '{1,   7,  0, 12'hFFF};
    vecs[15] = '{1, 650,  0, 12'h000};

    for (int i = 0; i < 4096; i++) begin
      vram_mem[i] = 8'($urandom);
      font_mem[i] = 8'($urandom);
    end
    vram_mem[0]      = 8'h41;
    font_mem[12'h410] = 8'h81;

    // Phase A: random screen content, reset released at cycle 0
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset state", 32'({red, green, blue, hsync, vsync, fstart}), 32'({12'h000, 1'b1, 1'b1, 1'b0}));
    rst = 1'b0;
    for (int n = 0; n <= RST_AT; n++) begin
      cycle_check(n);
      if (n == 1) check("font_addr for char 0x41", 32'(font_addr), 32'h410);
      if (n >= 3 && n < 3 + HT) rgb_log[n - 3] = {red, green, blue};
      if (n != RST_AT) @(negedge clk);
    end

    // One-cycle reset at (300,20); font switched to all ones meanwhile
    rst = 1'b1;
    for (int i = 0; i < 4096; i++) font_mem[i] = 8'hFF;
    @(negedge clk);
    check("mid-frame reset rgb", 32'({red, green, blue}), 32'h000);
    check("mid-frame reset syncs", 32'({hsync, vsync, fstart}), 32'b110);
    check("mid-frame reset addr", 32'(vram_addr), 32'd0);
    rst = 1'b0;

    // Phase B: a full frame with solid glyphs plus the start of the next one
    fs_first = -1; fs_second = -1; fs_count = 0;
    hs_low = 0; vs_low = 0; vs_first = -1; vs_last = -1;
    for (int n = 0; n <= FRAME + 10; n++) begin
      cycle_check(n);
      if (n < FRAME) addr_log[n] = vram_addr;
      if (fstart === 1'b1) begin
        fs_count++;
        if (fs_first < 0) fs_first = n;
        else if (fs_second < 0) fs_second = n;
      end
      if (n >= 3 && n < 3 + FRAME) begin
        if (hsync === 1'b0) hs_low++;
        if (vsync === 1'b0) begin
          vs_low++;
          if (vs_first < 0) vs_first = n;
          vs_last = n;
        end
      end
      @(negedge clk);
    end

    check("first frame_start after release", 32'(fs_first), 32'd3);
    check("frame_start period", 32'(fs_second - fs_first), 32'(FRAME));
    check("frame_start count", 32'(fs_count), 32'd2);
    check("hsync low cycles per frame", 32'(hs_low), 32'(HS * VT));
    check("vsync low cycles", 32'(vs_low), 32'(VS * HT));
    check("vsync low contiguous", 32'(vs_last - vs_first + 1), 32'(VS * HT));

    for (int i = 0; i < 16; i++) begin
      if (vecs[i].kind == 0)
        check($sformatf("table addr (%0d,%0d)", vecs[i].h, vecs[i].v),
              32'(addr_log[vecs[i].v * HT + vecs[i].h]), 32'(vecs[i].exp));
      else
        check($sformatf("table pixel (%0d,%0d)", vecs[i].h, vecs[i].v),
              32'(rgb_log[vecs[i].h]), 32'(vecs[i].exp));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
